// File: rtl/fir_pkg.sv
// Shared constants and state encoding for the streaming FIR MAC core.
package fir_pkg;

    localparam int FIR_ADDR_WIDTH = 12;
    localparam int FIR_DATA_WIDTH = 32;
    localparam int FIR_TAPS       = 11;
    localparam int ADDR_SHIFT     = 2;

    localparam logic [3:0] WE_ALL  = 4'hF;
    localparam logic [3:0] WE_NONE = 4'h0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_REQ     = 3'd2,
        ST_WAIT_IN = 3'd3,
        ST_MAC     = 3'd4,
        ST_DRAIN   = 3'd5,
        ST_OUT     = 3'd6,
        ST_DONE    = 3'd7
    } fir_state_e;

endpackage

// File: rtl/fir_mac_unit.sv
// One tap per cycle multiply-accumulate; keeps the low data word of each
// signed product and lets the running sum wrap.
module fir_mac_unit #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] coef,
    input  logic [W-1:0] smp,
    output logic [W-1:0] sum
);

    logic [W-1:0] acc_r;
    logic [W-1:0] prod_s;

    // The low word of a signed product equals the low word of the unsigned one.
    always_comb begin
        prod_s = coef * smp;
        sum    = acc_r + prod_s;
    end

    // Running sum, cleared while waiting for the next sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= '0;
        end else if (clr) begin
            acc_r <= '0;
        end else if (en) begin
            acc_r <= sum;
        end
    end

endmodule

// File: rtl/fir_mac_core.sv
// Streaming FIR core: requests one sample per result, sweeps Tape_Num taps over
// a circular data RAM and returns each sum on an AXI-Stream master.
module fir_mac_core
    import fir_pkg::*;
#(
    parameter int pADDR_WIDTH = FIR_ADDR_WIDTH,
    parameter int pDATA_WIDTH = FIR_DATA_WIDTH,
    parameter int Tape_Num    = FIR_TAPS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ap_start,
    input  logic [31:0]            data_length,
    output logic                   ap_done,
    input  logic [pDATA_WIDTH-1:0] strm_data,
    input  logic                   strm_valid,
    output logic                   fir_ready,
    output logic [pADDR_WIDTH-1:0] tap_A,
    input  logic [pDATA_WIDTH-1:0] tap_Do,
    output logic                   data_EN,
    output logic [3:0]             data_WE,
    output logic [pADDR_WIDTH-1:0] data_A,
    output logic [pDATA_WIDTH-1:0] data_Di,
    input  logic [pDATA_WIDTH-1:0] data_Do,
    output logic                   sm_tvalid,
    output logic [pDATA_WIDTH-1:0] sm_tdata,
    output logic                   sm_tlast,
    input  logic                   sm_tready
);

    localparam int            IW       = $clog2(Tape_Num);
    localparam logic [IW-1:0] LAST_IDX = IW'(Tape_Num - 1);
    localparam logic [IW-1:0] NUM_IDX  = IW'(Tape_Num);
    localparam logic [IW-1:0] ONE_IDX  = IW'(1);

    fir_state_e             state_r;
    logic [31:0]            len_r;
    logic [31:0]            out_cnt_r;
    logic [IW-1:0]          wptr_r;
    logic [IW-1:0]          cnt_r;
    logic                   acc_en_r;
    logic                   first_r;
    logic [IW-1:0]          cnt_nxt_s;
    logic                   acc_clr_s;
    logic [pDATA_WIDTH-1:0] mac_smp_s;
    logic [pDATA_WIDTH-1:0] mac_sum_s;

    function automatic logic [pADDR_WIDTH-1:0] word_addr(input logic [IW-1:0] idx);
        return {{(pADDR_WIDTH - IW){1'b0}}, idx} << ADDR_SHIFT;
    endfunction

    // (base - off) mod Tape_Num: add Tape_Num back when the subtraction underflows.
    function automatic logic [IW-1:0] circ_sub(input logic [IW-1:0] base, input logic [IW-1:0] off);
        if (base >= off) begin
            return base - off;
        end else begin
            return base - off + NUM_IDX;
        end
    endfunction

    // The newest sample is still being written on the first read, so take it from data_Di.
    always_comb begin
        cnt_nxt_s = cnt_r + ONE_IDX;
        acc_clr_s = (state_r == ST_WAIT_IN);
        if (first_r) begin
            mac_smp_s = data_Di;
        end else begin
            mac_smp_s = data_Do;
        end
    end

    fir_mac_unit #(
        .W(pDATA_WIDTH)
    ) u_mac (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (acc_clr_s),
        .en   (acc_en_r),
        .coef (tap_Do),
        .smp  (mac_smp_s),
        .sum  (mac_sum_s)
    );

    // Control FSM with all RAM and stream outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            len_r     <= 32'd0;
            out_cnt_r <= 32'd0;
            wptr_r    <= '0;
            cnt_r     <= '0;
            acc_en_r  <= 1'b0;
            first_r   <= 1'b0;
            fir_ready <= 1'b0;
            ap_done   <= 1'b0;
            sm_tvalid <= 1'b0;
            sm_tdata  <= '0;
            sm_tlast  <= 1'b0;
            data_EN   <= 1'b0;
            data_WE   <= WE_NONE;
            data_A    <= '0;
            data_Di   <= '0;
            tap_A     <= '0;
        end else begin
            acc_en_r <= 1'b0;
            first_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (ap_start) begin
                        len_r     <= data_length;
                        out_cnt_r <= 32'd0;
                        wptr_r    <= '0;
                        cnt_r     <= '0;
                        if (data_length == 32'd0) begin
                            state_r <= ST_DONE;
                            ap_done <= 1'b1;
                        end else begin
                            state_r <= ST_CLEAR;
                            data_EN <= 1'b1;
                            data_WE <= WE_ALL;
                            data_A  <= word_addr('0);
                            data_Di <= '0;
                        end
                    end
                end
                ST_CLEAR: begin
                    if (cnt_r == LAST_IDX) begin
                        state_r   <= ST_REQ;
                        data_EN   <= 1'b0;
                        data_WE   <= WE_NONE;
                        fir_ready <= 1'b1;
                    end else begin
                        cnt_r  <= cnt_nxt_s;
                        data_A <= word_addr(cnt_nxt_s);
                    end
                end
                ST_REQ: begin
                    fir_ready <= 1'b0;
                    state_r   <= ST_WAIT_IN;
                end
                ST_WAIT_IN: begin
                    if (strm_valid) begin
                        state_r <= ST_MAC;
                        cnt_r   <= '0;
                        data_EN <= 1'b1;
                        data_WE <= WE_ALL;
                        data_A  <= word_addr(wptr_r);
                        data_Di <= strm_data;
                        tap_A   <= word_addr('0);
                    end
                end
                ST_MAC: begin
                    acc_en_r <= 1'b1;
                    first_r  <= (cnt_r == '0);
                    data_WE  <= WE_NONE;
                    if (cnt_r == LAST_IDX) begin
                        state_r <= ST_DRAIN;
                        data_EN <= 1'b0;
                    end else begin
                        cnt_r  <= cnt_nxt_s;
                        tap_A  <= word_addr(cnt_nxt_s);
                        data_A <= word_addr(circ_sub(wptr_r, cnt_nxt_s));
                    end
                end
                ST_DRAIN: begin
                    state_r   <= ST_OUT;
                    sm_tvalid <= 1'b1;
                    sm_tdata  <= mac_sum_s;
                    sm_tlast  <= (out_cnt_r == len_r - 32'd1);
                end
                ST_OUT: begin
                    if (sm_tready) begin
                        sm_tvalid <= 1'b0;
                        sm_tlast  <= 1'b0;
                        out_cnt_r <= out_cnt_r + 32'd1;
                        wptr_r    <= (wptr_r == LAST_IDX) ? '0 : wptr_r + ONE_IDX;
                        if (sm_tlast) begin
                            state_r <= ST_DONE;
                            ap_done <= 1'b1;
                        end else begin
                            state_r   <= ST_REQ;
                            fir_ready <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    ap_done <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_core.sv
// Self-checking bench for fir_mac_core: RAM models, a one-shot input stage
// and a convolution reference model.
module tb_fir_mac_core;

    localparam int AW   = 12;
    localparam int DW   = 32;
    localparam int TAPS = 11;

    logic          clk = 1'b0;
    logic          rst_n, ap_start, ap_done, strm_valid, fir_ready;
    logic          data_EN, sm_tvalid, sm_tlast, sm_tready;
    logic [31:0]   data_length;
    logic [DW-1:0] strm_data, tap_Do, data_Do, data_Di, sm_tdata;
    logic [AW-1:0] tap_A, data_A;
    logic [3:0]    data_WE;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [DW-1:0] tap_mem [0:15];
    logic [DW-1:0] dmem    [0:15];
    logic [31:0]   xs[$];
    logic [31:0]   exp_q[$];

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
    } vec_t;
    vec_t imp_tab [TAPS];

    always #5 clk = ~clk;

    fir_mac_core #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(TAPS)) dut (
        .clk(clk), .rst_n(rst_n), .ap_start(ap_start), .data_length(data_length),
        .ap_done(ap_done), .strm_data(strm_data), .strm_valid(strm_valid),
        .fir_ready(fir_ready), .tap_A(tap_A), .tap_Do(tap_Do), .data_EN(data_EN),
        .data_WE(data_WE), .data_A(data_A), .data_Di(data_Di), .data_Do(data_Do),
        .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast),
        .sm_tready(sm_tready));

    // Cycle counter and synchronous-read tap/data RAMs.
    always @(posedge clk) begin
        cyc    <= cyc + 1;
        tap_Do <= tap_mem[tap_A[5:2]];
        if (data_EN) begin
            if (data_WE == 4'hF) dmem[data_A[5:2]] <= data_Di;
            data_Do <= dmem[data_A[5:2]];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // y[n] = sum over k of tap[k] * x[n-k], 32-bit two's-complement wrap.
    function automatic logic [31:0] model_y(input int n);
        int acc = 0;
        for (int k = 0; k < TAPS; k++)
            if (n - k >= 0) acc += int'(tap_mem[k]) * int'(xs[n - k]);
        return acc;
    endfunction

    task automatic build_exp(input int len);
        exp_q.delete();
        for (int n = 0; n < len; n++) exp_q.push_back(model_y(n));
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_fir_ready"}, fir_ready, 0);
        check({tag, "_ap_done"},   ap_done,   0);
        check({tag, "_tvalid"},    sm_tvalid, 0);
        check({tag, "_tdata"},     sm_tdata,  0);
        check({tag, "_tlast"},     sm_tlast,  0);
        check({tag, "_data_EN"},   data_EN,   0);
        check({tag, "_data_WE"},   data_WE,   0);
        check({tag, "_data_A"},    data_A,    0);
        check({tag, "_data_Di"},   data_Di,   0);
        check({tag, "_tap_A"},     tap_A,     0);
    endtask

    task automatic recover();
        strm_valid = 1'b0; sm_tready = 1'b0; ap_start = 1'b0;
        rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; @(negedge clk);
    endtask

    task automatic start_run(input int len, output bit ok);
        int w;
        ap_start = 1'b1; data_length = len;
        @(negedge clk);
        ap_start = 1'b0; data_length = $urandom;
        w = 1;
        while (fir_ready !== 1'b1 && w < 200) begin @(negedge clk); w++; end
        check("first_req_latency", w, TAPS + 1);
        ok = (fir_ready === 1'b1);
    endtask

    task automatic run_samples(input int len, input int stall, input int dly_max,
                               input bit junk, input bit chk_period);
        int lat, d, t_prev;
        bit req_seen;
        t_prev = cyc;
        for (int n = 0; n < len; n++) begin
            if (chk_period && n > 0) check($sformatf("req_period[%0d]", n), cyc - t_prev, TAPS + 4);
            t_prev = cyc;
            if (junk) begin strm_valid = 1'b1; strm_data = $urandom; end
            @(negedge clk);
            strm_valid = 1'b0;
            check($sformatf("req_pulse[%0d]", n), fir_ready, 0);
            d = $urandom_range(dly_max, 0);
            repeat (d) @(negedge clk);
            strm_valid = 1'b1; strm_data = xs[n];
            @(negedge clk);
            strm_valid = 1'b0; strm_data = $urandom;
            lat = 1; req_seen = 1'b0;
            while (sm_tvalid !== 1'b1 && lat < 100) begin
                ap_start = (junk && lat == 3);
                data_length = 32'd2;
                @(negedge clk);
                if (fir_ready) req_seen = 1'b1;
                lat++;
            end
            ap_start = 1'b0;
            check($sformatf("out_latency[%0d]", n), lat, TAPS + 2);
            check($sformatf("no_req_busy[%0d]", n), req_seen, 0);
            if (sm_tvalid !== 1'b1) begin recover(); return; end
            for (int s = 0; s < stall; s++) begin
                check($sformatf("hold_tdata[%0d]", n), sm_tdata, exp_q[n]);
                check($sformatf("hold_tlast[%0d]", n), sm_tlast, n == len - 1);
                check($sformatf("hold_tvalid[%0d]", n), sm_tvalid, 1);
                check($sformatf("hold_noreq[%0d]", n), fir_ready, 0);
                @(negedge clk);
            end
            sm_tready = 1'b1;
            check($sformatf("tdata[%0d]", n), sm_tdata, exp_q[n]);
            check($sformatf("tlast[%0d]", n), sm_tlast, n == len - 1);
            @(negedge clk);
            sm_tready = 1'b0;
            check($sformatf("tvalid_drop[%0d]", n), sm_tvalid, 0);
            if (n == len - 1) begin
                check("ap_done_pulse", ap_done, 1);
                @(negedge clk);
                check("ap_done_clear", ap_done, 0);
            end else begin
                check($sformatf("next_req[%0d]", n), fir_ready, 1);
                if (fir_ready !== 1'b1) begin recover(); return; end
            end
        end
    endtask

    task automatic do_run(input int len, input int stall, input int dly_max,
                          input bit junk, input bit chk_period);
        bit ok;
        start_run(len, ok);
        if (ok) run_samples(len, stall, dly_max, junk, chk_period);
        else recover();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit ok, seen;
        int len;
        imp_tab = '{'{32'd1, 32'd1}, '{32'd0, 32'd2}, '{32'd0, 32'd3}, '{32'd0, 32'd4},
                    '{32'd0, 32'd5}, '{32'd0, 32'd6}, '{32'd0, 32'd7}, '{32'd0, 32'd8},
                    '{32'd0, 32'd9}, '{32'd0, 32'd10}, '{32'd0, 32'd11}};
        rst_n = 1'b0; ap_start = 1'b0; data_length = 32'd0;
        strm_valid = 1'b0; strm_data = 32'd0; sm_tready = 1'b0;
        for (int k = 0; k < 16; k++) tap_mem[k] = 32'd0;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // zero-length run
        ap_start = 1'b1; data_length = 32'd0;
        @(negedge clk);
        ap_start = 1'b0;
        check("len0_done", ap_done, 1);
        check("len0_ready", fir_ready, 0);
        check("len0_tvalid", sm_tvalid, 0);
        @(negedge clk);
        check("len0_done_clear", ap_done, 0);
        seen = 1'b0;
        repeat (20) begin @(negedge clk); if (fir_ready || sm_tvalid) seen = 1'b1; end
        check("len0_quiet", seen, 0);

        // impulse response from the vector table
        for (int k = 0; k < TAPS; k++) tap_mem[k] = k + 1;
        xs.delete(); exp_q.delete();
        for (int i = 0; i < TAPS; i++) begin
            xs.push_back(imp_tab[i].x);
            exp_q.push_back(imp_tab[i].y);
        end
        do_run(TAPS, 0, 0, 0, 1);

        // step with write-pointer wrap
        for (int k = 0; k < TAPS; k++) tap_mem[k] = 32'd1;
        xs.delete();
        for (int i = 1; i <= 20; i++) xs.push_back(i);
        build_exp(20);
        do_run(20, 0, 0, 0, 1);

        // backpressure on every result
        for (int k = 0; k < TAPS; k++) tap_mem[k] = $urandom;
        xs.delete();
        for (int i = 0; i < 14; i++) xs.push_back($urandom);
        build_exp(14);
        do_run(14, 7, 0, 0, 0);

        // signed overflow wrap
        for (int k = 0; k < TAPS; k++) tap_mem[k] = 32'h7FFF_FFFF;
        xs.delete();
        for (int i = 0; i < 12; i++) xs.push_back(32'd2);
        build_exp(12);
        do_run(12, 0, 1, 0, 0);

        // second run directly after: history must be cleared
        for (int k = 0; k < TAPS; k++) tap_mem[k] = $urandom;
        xs.delete();
        for (int i = 0; i < 3; i++) xs.push_back($urandom);
        build_exp(3);
        do_run(3, 0, 0, 0, 0);

        // random run with stray strm_valid, ap_start and input delays
        len = $urandom_range(25, 15);
        for (int k = 0; k < TAPS; k++) tap_mem[k] = $urandom;
        xs.delete();
        for (int i = 0; i < len; i++) xs.push_back($urandom);
        build_exp(len);
        do_run(len, 2, 3, 1, 0);

        // reset in the middle of a tap sweep, then a clean run
        start_run(5, ok);
        if (ok) begin
            @(negedge clk);
            strm_valid = 1'b1; strm_data = $urandom;
            @(negedge clk);
            strm_valid = 1'b0;
            repeat (4) @(negedge clk);
            check("pre_reset_in_mac", data_EN, 1);
            rst_n = 1'b0;
            #1;
            chk_reset("mid_mac");
            @(negedge clk);
            rst_n = 1'b1;
        end else begin
            recover();
        end
        for (int k = 0; k < TAPS; k++) tap_mem[k] = $urandom;
        xs.delete();
        for (int i = 0; i < 6; i++) xs.push_back($urandom);
        build_exp(6);
        do_run(6, 1, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
